// File: rtl/spatz_tcdm_bank.sv
// spatz_tcdm_bank: single-port TCDM bank with strobed writes, fixed-latency
// responses carrying the pre-access word, and optional atomic memory ops.
// Optional feature macro: SPATZ_TCDM_BANK_AMO_EN enables the AMO ALU and the
// AMO write-back state; without it q_amo_i is ignored and q_ready_o is tied 1.
// MemoryResponseLatency is legal in 1..4.
module spatz_tcdm_bank #(
  parameter int unsigned NumWords              = 512,
  parameter int unsigned DataWidth             = 64,
  parameter int unsigned AddrWidth             = $clog2(NumWords),
  parameter int unsigned MemoryResponseLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   q_valid_i,
  output logic                   q_ready_o,
  input  logic [AddrWidth-1:0]   q_addr_i,
  input  logic                   q_write_i,
  input  logic [3:0]             q_amo_i,
  input  logic [DataWidth-1:0]   q_data_i,
  input  logic [DataWidth/8-1:0] q_strb_i,
  output logic [DataWidth-1:0]   p_data_o,
  output logic                   p_valid_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned Lat       = MemoryResponseLatency;

  // Storage array; intentionally not reset.
  logic [DataWidth-1:0] mem_q [NumWords];

  logic                 req_hs;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_waddr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_wmask;
  logic [DataWidth-1:0] strb_mask;

  // Response pipeline: stage 0 is the array read stage.
  logic [Lat-1:0]       valid_q, valid_d;
  logic [DataWidth-1:0] data_q [Lat];
  logic [DataWidth-1:0] data_d [Lat];

  assign req_hs = q_valid_i & q_ready_o;

  // Expand byte strobes into a bit mask.
  always_comb begin
    strb_mask = '0;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      strb_mask[b*8 +: 8] = {8{q_strb_i[b]}};
    end
  end

`ifdef SPATZ_TCDM_BANK_AMO_EN
  typedef enum logic [0:0] {StIdle, StAmoWb} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] amo_addr_q, amo_addr_d;
  logic [DataWidth-1:0] amo_opnd_q, amo_opnd_d;
  logic [3:0]           amo_op_q, amo_op_d;
  logic                 amo_req;
  logic [DataWidth-1:0] amo_old;
  logic [DataWidth-1:0] amo_result;

  assign amo_req = (q_amo_i >= 4'd1) && (q_amo_i <= 4'd9);
  // The old word was latched into the read stage when the AMO was accepted
  // and stays there during write-back because nothing else is accepted.
  assign amo_old = data_q[0];

  // AMO FSM: next state, captured operands and request readiness.
  always_comb begin
    state_d    = state_q;
    amo_addr_d = amo_addr_q;
    amo_opnd_d = amo_opnd_q;
    amo_op_d   = amo_op_q;
    q_ready_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        q_ready_o = 1'b1;
        if (q_valid_i && amo_req) begin
          state_d    = StAmoWb;
          amo_addr_d = q_addr_i;
          amo_opnd_d = q_data_i;
          amo_op_d   = q_amo_i;
        end
      end
      StAmoWb: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // AMO ALU over the full word.
  always_comb begin
    amo_result = amo_opnd_q;
    case (amo_op_q)
      4'd1: amo_result = amo_opnd_q;
      4'd2: amo_result = amo_old + amo_opnd_q;
      4'd3: amo_result = amo_old & amo_opnd_q;
      4'd4: amo_result = amo_old | amo_opnd_q;
      4'd5: amo_result = amo_old ^ amo_opnd_q;
      4'd6: amo_result = ($signed(amo_old) > $signed(amo_opnd_q)) ? amo_old : amo_opnd_q;
      4'd7: amo_result = (amo_old > amo_opnd_q) ? amo_old : amo_opnd_q;
      4'd8: amo_result = ($signed(amo_old) < $signed(amo_opnd_q)) ? amo_old : amo_opnd_q;
      4'd9: amo_result = (amo_old < amo_opnd_q) ? amo_old : amo_opnd_q;
      default: amo_result = amo_opnd_q;
    endcase
  end

  // Array write port: AMO write-back has priority, plain writes otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = q_addr_i;
    mem_wdata = q_data_i;
    mem_wmask = strb_mask;
    if (state_q == StAmoWb) begin
      mem_we    = 1'b1;
      mem_waddr = amo_addr_q;
      mem_wdata = amo_result;
      mem_wmask = '1;
    end else if (req_hs && q_write_i && !amo_req) begin
      mem_we = 1'b1;
    end
  end

  // AMO FSM state and operand registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      amo_addr_q <= '0;
      amo_opnd_q <= '0;
      amo_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      amo_addr_q <= amo_addr_d;
      amo_opnd_q <= amo_opnd_d;
      amo_op_q   <= amo_op_d;
    end
  end
`else
  logic unused_amo;

  assign unused_amo = ^q_amo_i;
  assign q_ready_o  = 1'b1;

  // Array write port: plain strobed writes only.
  always_comb begin
    mem_we    = req_hs & q_write_i;
    mem_waddr = q_addr_i;
    mem_wdata = q_data_i;
    mem_wmask = strb_mask;
  end
`endif

  // Array write; bytes outside the mask keep their content.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // Response pipeline next state; data only moves with a valid beat so the
  // output holds its last value between responses.
  always_comb begin
    valid_d[0] = req_hs;
    data_d[0]  = req_hs ? mem_q[q_addr_i] : data_q[0];
    for (int unsigned i = 1; i < Lat; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  // Response pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Lat; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < Lat; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign p_valid_o = valid_q[Lat-1];
  assign p_data_o  = data_q[Lat-1];

endmodule

// File: tb/tb_spatz_tcdm_bank.sv
// Bench for spatz_tcdm_bank: two instances (latency 1 and 3) share one request
// stream; a word-level memory model predicts every response, which per-port
// monitors compare in content and exact arrival cycle.
module tb_spatz_tcdm_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        q_valid_i;
  logic        q_write_i;
  logic [3:0]  q_amo_i;
  logic [8:0]  q_addr_i;
  logic [63:0] q_data_i;
  logic [7:0]  q_strb_i;
  logic        rdy1, rdy3, pv1, pv3;
  logic [63:0] pd1, pd3;

  always #5 clk_i = ~clk_i;

  spatz_tcdm_bank #(.MemoryResponseLatency(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .q_valid_i(q_valid_i), .q_ready_o(rdy1),
    .q_addr_i(q_addr_i), .q_write_i(q_write_i), .q_amo_i(q_amo_i), .q_data_i(q_data_i),
    .q_strb_i(q_strb_i), .p_data_o(pd1), .p_valid_o(pv1)
  );

  spatz_tcdm_bank #(.MemoryResponseLatency(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .q_valid_i(q_valid_i), .q_ready_o(rdy3),
    .q_addr_i(q_addr_i), .q_write_i(q_write_i), .q_amo_i(q_amo_i), .q_data_i(q_data_i),
    .q_strb_i(q_strb_i), .p_data_o(pd3), .p_valid_o(pv3)
  );

`ifdef SPATZ_TCDM_BANK_AMO_EN
  localparam bit AmoEn = 1'b1;
`else
  localparam bit AmoEn = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // Reference model state.
  logic [63:0] mem_m [16];
  bit          amo_pend = 1'b0;
  int          pa;
  logic [63:0] pv;
  bit          exp_rdy = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] amo_calc(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      4'd1: return b;
      4'd2: return a + b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return ($signed(a) > $signed(b)) ? a : b;
      4'd7: return (a > b) ? a : b;
      4'd8: return ($signed(a) < $signed(b)) ? a : b;
      4'd9: return (a < b) ? a : b;
      default: return a;
    endcase
  endfunction

  // Advance one cycle; a pending AMO writes back during the cycle it blocks.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (amo_pend) begin
      exp_rdy  = 1'b0;
      mem_m[pa] = pv;
      amo_pend = 1'b0;
    end else begin
      exp_rdy = 1'b1;
    end
    chk("ready_lat1", {63'd0, rdy1}, {63'd0, exp_rdy});
    chk("ready_lat3", {63'd0, rdy3}, {63'd0, exp_rdy});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      q_valid_i = 1'b0;
    end
  endtask

  task automatic issue(input bit wr, input logic [3:0] amo, input int a,
                       input logic [63:0] d, input logic [7:0] s);
    bit   done = 1'b0;
    exp_t e;
    while (!done) begin
      step();
      q_valid_i = 1'b1;
      q_write_i = wr;
      q_amo_i   = amo;
      q_addr_i  = 9'(a);
      q_data_i  = d;
      q_strb_i  = s;
      if (exp_rdy) begin
        done  = 1'b1;
        e.d   = mem_m[a];
        e.due = cyc + 1;
        q1.push_back(e);
        e.due = cyc + 3;
        q3.push_back(e);
        if (AmoEn && amo >= 4'd1 && amo <= 4'd9) begin
          amo_pend = 1'b1;
          pa       = a;
          pv       = amo_calc(amo, mem_m[a], d);
        end else if (wr) begin
          for (int b = 0; b < 8; b++) begin
            if (s[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
          end
        end
      end
    end
  endtask

  // Asynchronous reset in mid-cycle; in-flight work is discarded.
  task automatic do_reset();
    @(posedge clk_i);
    #1;
    q_valid_i = 1'b0;
    rst_ni    = 1'b0;
    #1;
    chk("rst_pvalid1", {63'd0, pv1}, 64'd0);
    chk("rst_pvalid3", {63'd0, pv3}, 64'd0);
    chk("rst_pdata1", pd1, 64'd0);
    chk("rst_pdata3", pd3, 64'd0);
    chk("rst_ready", {63'd0, rdy1}, 64'd1);
    amo_pend = 1'b0;
    q1.delete();
    q3.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Latency-1 monitor.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (pv1) begin
        if (q1.size() == 0) begin
          chk("lat1_spurious", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("lat1_data", pd1, e.d);
          chk("lat1_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        chk("lat1_missing", 64'd0, 64'd1);
        void'(q1.pop_front());
      end
    end
  end

  // Latency-3 monitor.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (pv3) begin
        if (q3.size() == 0) begin
          chk("lat3_spurious", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q3.pop_front();
          chk("lat3_data", pd3, e.d);
          chk("lat3_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (q3.size() > 0 && q3[0].due <= cyc) begin
        chk("lat3_missing", 64'd0, 64'd1);
        void'(q3.pop_front());
      end
    end
  end

  initial begin
    rst_ni    = 1'b0;
    q_valid_i = 1'b0;
    q_write_i = 1'b0;
    q_amo_i   = 4'd0;
    q_addr_i  = '0;
    q_data_i  = '0;
    q_strb_i  = '0;
    #1;
    chk("init_pvalid", {62'd0, pv1, pv3}, 64'd0);
    chk("init_pdata", pd1 | pd3, 64'd0);
    chk("init_ready", {62'd0, rdy1, rdy3}, 64'd3);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Give every modelled word a known value.
    for (int a = 0; a < 16; a++) issue(1'b1, 4'd0, a, {$urandom, $urandom}, 8'hFF);

    // Full write then read back.
    issue(1'b1, 4'd0, 5, 64'h1122334455667788, 8'hFF);
    issue(1'b0, 4'd0, 5, 64'd0, 8'h00);
    // Upper-half strobed write.
    issue(1'b1, 4'd0, 3, 64'h00000000FFFFFFFF, 8'hFF);
    issue(1'b1, 4'd0, 3, 64'hAAAAAAAAAAAAAAAA, 8'hF0);
    issue(1'b0, 4'd0, 3, 64'd0, 8'h00);
    // AMO add, then readback.
    issue(1'b1, 4'd0, 7, 64'd10, 8'hFF);
    issue(1'b0, 4'd2, 7, 64'd5, 8'h00);
    issue(1'b0, 4'd0, 7, 64'd0, 8'h00);
    // Signed versus unsigned max on an all-ones word.
    issue(1'b1, 4'd0, 2, '1, 8'hFF);
    issue(1'b0, 4'd6, 2, 64'd1, 8'h00);
    issue(1'b0, 4'd0, 2, 64'd0, 8'h00);
    issue(1'b1, 4'd0, 2, '1, 8'hFF);
    issue(1'b1, 4'd7, 2, 64'd1, 8'h00);
    issue(1'b0, 4'd0, 2, 64'd0, 8'h00);
    // Back-to-back reads after a quiet period.
    idle(3);
    issue(1'b0, 4'd0, 0, 64'd0, 8'h00);
    issue(1'b0, 4'd0, 1, 64'd0, 8'h00);
    issue(1'b0, 4'd0, 2, 64'd0, 8'h00);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        idle($urandom_range(3, 1));
      end else begin
        issue(1'($urandom), 4'($urandom), $urandom_range(15), {$urandom, $urandom},
              8'($urandom));
      end
    end

    // Reset during the write-back of a swap; the old word must survive.
    issue(1'b1, 4'd0, 4, 64'd9, 8'hFF);
    issue(1'b0, 4'd1, 4, 64'd1, 8'h00);
    do_reset();
    issue(1'b0, 4'd0, 4, 64'd0, 8'h00);
    idle(4);

    // Reset with responses still inside the deeper pipeline.
    issue(1'b0, 4'd0, 0, 64'd0, 8'h00);
    issue(1'b0, 4'd0, 1, 64'd0, 8'h00);
    do_reset();
    issue(1'b0, 4'd0, 6, 64'd0, 8'h00);

    idle(6);
    chk("drain_lat1", 64'(q1.size()), 64'd0);
    chk("drain_lat3", 64'(q3.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
